ysyx_24080006_axi_slave_mem: RTL and testbench

YSYX_24080006_AXI_SLAVE_MEM -- requirements
Module: ysyx_24080006_axi_slave_mem

---
 rtl/ysyx_24080006_axi_slave_mem.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_24080006_axi_slave_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_axi_slave_mem.sv
// ysyx_24080006_axi_slave_mem: AXI4 slave responder backed by a word-addressed memory with independent read/write FSMs
module ysyx_24080006_axi_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0F00_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT > 0 ? RD_LAT - 1 : 0);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [31:0] mem [DEPTH_WORDS];
  function automatic logic in_range(input logic [31:0] a);
    return a >= BASE_ADDR && a - BASE_ADDR < SPAN;
  endfunction
  function automatic logic [IW-1:0] widx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction
  function automatic logic bad(input logic [2:0] s, input logic [1:0] b);
    return b[1] || s > 3'd2;
  endfunction
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    return b == 2'b01 ? a + (32'd1 << s) : a;
  endfunction
  r_state_e    r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic [3:0]  rid_q, rid_d, rwait_q, rwait_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d, rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        ld;
  logic [31:0] ld_addr;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst;
  logic [7:0]  ld_cnt, ld_len;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wid_q, wid_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d, bresp_q, bresp_d;
  logic        dec_q, dec_d, slv_q, slv_d;
  logic        w_in, w_last_beat, wen;
  assign arready = !reset && r_state_q == R_IDLE;
  assign rvalid  = !reset && r_state_q == R_DATA;
  assign rdata   = rdata_q;
  assign rresp   = reset ? 2'b00 : rresp_q;
  assign rlast   = !reset && rlast_q;
  assign rid     = rid_q;
  assign awready = !reset && w_state_q == W_IDLE;
  assign wready  = !reset && w_state_q == W_DATA;
  assign bvalid  = !reset && w_state_q == W_RESP;
  assign bresp   = reset ? 2'b00 : bresp_q;
  assign bid     = wid_q;
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rwait_d   = rwait_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ld        = 1'b0;
    ld_addr   = raddr_q;
    ld_size   = rsize_q;
    ld_burst  = rburst_q;
    ld_cnt    = rcnt_q;
    ld_len    = rlen_q;
    if (arvalid && arready) begin
      raddr_d   = araddr;
      rid_d     = arid;
      rlen_d    = arlen;
      rsize_d   = arsize;
      rburst_d  = arburst;
      rcnt_d    = '0;
      rwait_d   = '0;
      r_state_d = RD_LAT == 0 ? R_DATA : R_WAIT;
      ld        = RD_LAT == 0;
      ld_addr   = araddr;
      ld_size   = arsize;
      ld_burst  = arburst;
      ld_cnt    = '0;
      ld_len    = arlen;
    end else if (r_state_q == R_WAIT) begin
      rwait_d   = rwait_q + 4'd1;
      r_state_d = rwait_q == LAT_M1 ? R_DATA : R_WAIT;
      ld        = rwait_q == LAT_M1;
    end else if (rvalid && rready) begin
      r_state_d = rlast_q ? R_IDLE : R_DATA;
      raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
      rcnt_d    = rlast_q ? rcnt_q : rcnt_q + 8'd1;
      ld        = !rlast_q;
      ld_addr   = raddr_d;
      ld_cnt    = rcnt_d;
    end
    if (ld) begin
      rresp_d = !in_range(ld_addr) ? 2'b11 : bad(ld_size, ld_burst) ? 2'b10 : 2'b00;
      rdata_d = rresp_d == 2'b00 ? mem[widx(ld_addr)] : '0;
      rlast_d = ld_cnt == ld_len;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rwait_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rwait_q   <= rwait_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end
  always_comb begin
    w_state_d   = w_state_q;
    waddr_d     = waddr_q;
    wid_d       = wid_q;
    wlen_d      = wlen_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    wcnt_d      = wcnt_q;
    dec_d       = dec_q;
    slv_d       = slv_q;
    bresp_d     = bresp_q;
    w_in        = in_range(waddr_q);
    w_last_beat = wcnt_q == wlen_q;
    wen         = 1'b0;
    if (awvalid && awready) begin
      waddr_d   = awaddr;
      wid_d     = awid;
      wlen_d    = awlen;
      wsize_d   = awsize;
      wburst_d  = awburst;
      wcnt_d    = '0;
      dec_d     = 1'b0;
      slv_d     = bad(awsize, awburst);
      w_state_d = W_DATA;
    end else if (wvalid && wready) begin
      wen       = w_in && !bad(wsize_q, wburst_q);
      dec_d     = dec_q || !w_in;
      slv_d     = slv_q || (wlast != w_last_beat);
      waddr_d   = next_addr(waddr_q, wsize_q, wburst_q);
      wcnt_d    = w_last_beat ? wcnt_q : wcnt_q + 8'd1;
      w_state_d = w_last_beat ? W_RESP : W_DATA;
      bresp_d   = dec_d ? 2'b11 : slv_d ? 2'b10 : 2'b00;
    end else if (bvalid && bready) begin
      w_state_d = W_IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wid_q     <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      dec_q     <= 1'b0;
      slv_q     <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wid_q     <= wid_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      dec_q     <= dec_d;
      slv_q     <= slv_d;
      bresp_q   <= bresp_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wen) for (int i = 0; i < 4; i++) if (wstrb[i]) mem[widx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_24080006_axi_slave_mem.sv
// tb_ysyx_24080006_axi_slave_mem: randomized AXI traffic checked against a behavioural memory model
module tb_ysyx_24080006_axi_slave_mem;
  localparam logic [31:0] BASE = 32'h0F00_0000;
  localparam int DEPTH = 1024;
  localparam int LAT = 1;
  logic clock = 0, reset = 1;
  logic awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0, rlast;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] awid = 0, wstrb = 0, bid, arid = 0, rid;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, bresp, arburst = 0, rresp;
  ysyx_24080006_axi_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );
  always #5 clock = ~clock;
  int total = 0, passed = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  typedef struct {logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id;} rbeat_t;
  typedef struct {logic [1:0] r; logic [3:0] id;} bexp_t;
  rbeat_t exp_r[$];
  bexp_t exp_b[$];
  logic [31:0] mm [DEPTH];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  logic [31:0] got_d [256];
  logic [1:0] got_r [256];
  logic [1:0] got_b;
  int got_lat;
  function automatic logic [31:0] baddr(input logic [31:0] a, input int k, input logic [2:0] s, input logic [1:0] b);
    return b == 2'b01 ? a + 32'(k * (1 << s)) : a;
  endfunction
  function automatic bit inr(input logic [31:0] a);
    longint x = longint'(a);
    return x >= longint'(BASE) && x < longint'(BASE) + 4 * DEPTH;
  endfunction
  function automatic int midx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & (DEPTH - 1));
  endfunction
  function automatic bit bad(input logic [2:0] s, input logic [1:0] b);
    return b >= 2 || s > 2;
  endfunction
  always @(negedge clock) begin
    if (!reset && rvalid) begin
      if (exp_r.size() == 0) chk("r_spurious_valid", rvalid, 0);
      else begin
        chk("r_data", rdata, exp_r[0].d);
        chk("r_resp", rresp, exp_r[0].r);
        chk("r_last", rlast, exp_r[0].l);
        chk("r_id", rid, exp_r[0].id);
        if (rready) void'(exp_r.pop_front());
      end
    end
    if (!reset && bvalid) begin
      if (exp_b.size() == 0) chk("b_spurious_valid", bvalid, 0);
      else begin
        chk("b_resp", bresp, exp_b[0].r);
        chk("b_id", bid, exp_b[0].id);
        if (bready) void'(exp_b.pop_front());
      end
    end
  end
  task automatic do_reset(input int n);
    reset = 1;
    exp_r.delete();
    exp_b.delete();
    {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
    repeat (n) begin
      @(negedge clock);
      chk("rst_arready", arready, 0);
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_bresp", bresp, 0);
    end
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("post_rst_arready", arready, 1);
    chk("post_rst_awready", awready, 1);
    @(posedge clock); #1;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input int len, input logic [2:0] s, input logic [1:0] b, input int wl);
    bit dec = 0, slv = bad(s, b), hs = 0;
    int k = 0, cyc = 0;
    for (int j = 0; j <= len; j++) begin
      logic [31:0] ba = baddr(a, j, s, b);
      if (inr(ba) && !bad(s, b))
        for (int i = 0; i < 4; i++) if (ws[j][i]) mm[midx(ba)][8*i +: 8] = wd[j][8*i +: 8];
      dec |= !inr(ba);
      slv |= (j == wl) != (j == len);
    end
    exp_b.push_back('{r: dec ? 2'b11 : slv ? 2'b10 : 2'b00, id: id});
    awaddr = a; awid = id; awlen = 8'(len); awsize = s; awburst = b; awvalid = 1;
    while (!hs && cyc < 50) begin
      @(negedge clock); hs = awready;
      @(posedge clock); #1; cyc++;
    end
    awvalid = 0;
    chk("aw_handshake", hs, 1);
    cyc = 0;
    while (k <= len && cyc < 3000) begin
      wvalid = $urandom_range(3) != 0; wdata = wd[k]; wstrb = ws[k]; wlast = k == wl;
      @(negedge clock); hs = wvalid && wready;
      @(posedge clock); #1; cyc++;
      if (hs) k++;
    end
    wvalid = 0; wlast = 0;
    chk("w_beats", k, len + 1);
    @(negedge clock);
    chk("b_latency", bvalid, 1);
    hs = 0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(posedge clock); #1; bready = $urandom_range(2) != 0;
      @(negedge clock);
      if (bvalid && bready) begin hs = 1; got_b = bresp; end
      cyc++;
    end
    chk("b_handshake", hs, 1);
    @(posedge clock); #1 bready = 0;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int len, input logic [2:0] s, input logic [1:0] b,
                         input int stall_beat, input int stall_n, input int rst_beat);
    bit hs = 0;
    int beats = 0, cyc = 0, stalled = 0;
    for (int j = 0; j <= len; j++) begin
      logic [31:0] ba = baddr(a, j, s, b);
      logic [1:0] r = !inr(ba) ? 2'b11 : bad(s, b) ? 2'b10 : 2'b00;
      exp_r.push_back('{d: r == 0 ? mm[midx(ba)] : 32'h0, r: r, l: j == len, id: id});
    end
    araddr = a; arid = id; arlen = 8'(len); arsize = s; arburst = b; arvalid = 1;
    while (!hs && cyc < 50) begin
      @(negedge clock); hs = arready;
      @(posedge clock); #1; cyc++;
    end
    arvalid = 0;
    chk("ar_handshake", hs, 1);
    got_lat = 0;
    do begin @(negedge clock); got_lat++; end while (!rvalid && got_lat < 40);
    chk("r_latency", got_lat, LAT + 1);
    cyc = 0;
    while (beats <= len && cyc < 4000) begin
      @(posedge clock); #1;
      if (beats == rst_beat) begin do_reset(2); return; end
      rready = (beats == stall_beat && stalled < stall_n) ? 1'b0 : $urandom_range(3) != 0;
      @(negedge clock);
      if (rvalid && rready) begin got_d[beats] = rdata; got_r[beats] = rresp; beats++; end
      else if (rvalid && beats == stall_beat) stalled++;
      cyc++;
    end
    chk("r_beats", beats, len + 1);
    @(posedge clock); #1 rready = 0;
  endtask
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    do_reset(3);
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(BASE + 32'(blk * 1024), 4'(blk), 255, 2, 1, 255);
      chk("init_bresp", got_b, 0);
    end
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    do_write(BASE, 2, 3, 2, 1, 3);
    chk("incr_bresp", got_b, 0);
    chk("model_word0", mm[0], 1);
    do_read(BASE, 3, 3, 2, 1, -1, 0, -1);
    for (int k = 0; k < 4; k++) begin
      chk("incr_rdata", got_d[k], 32'(k + 1));
      chk("incr_rresp", got_r[k], 0);
    end
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
    do_write(BASE + 32'h10, 4, 0, 2, 1, 0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(BASE + 32'h10, 4, 0, 2, 1, 0);
    chk("model_strobe", mm[4], 32'hAA22_CC44);
    do_read(BASE + 32'h10, 5, 0, 2, 1, -1, 0, -1);
    chk("strobe_rdata", got_d[0], 32'hAA22_CC44);
    do_read(BASE + 32'h1000, 6, 1, 2, 1, -1, 0, -1);
    for (int k = 0; k < 2; k++) begin
      chk("oor_rdata", got_d[k], 0);
      chk("oor_rresp", got_r[k], 2'b11);
    end
    for (int k = 0; k < 2; k++) begin wd[k] = 32'hDEAD_0000 + 32'(k); ws[k] = 4'hF; end
    do_write(BASE + 32'h1000, 7, 1, 2, 1, 1);
    chk("oor_bresp", got_b, 2'b11);
    do_read(BASE, 8, 1, 2, 1, -1, 0, -1);
    chk("oor_no_alias0", got_d[0], 1);
    chk("oor_no_alias1", got_d[1], 2);
    do_read(BASE, 9, 2, 2, 1, 1, 3, -1);
    chk("stall_latency", got_lat, 2);
    for (int k = 0; k < 3; k++) chk("stall_rdata", got_d[k], 32'(k + 1));
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'h0; end
    do_write(BASE + 32'h100, 10, 3, 2, 1, 2);
    chk("wlast_bresp", got_b, 2'b10);
    do_read(BASE, 11, 3, 2, 2, -1, 0, -1);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_rresp", got_r[k], 2'b10);
      chk("wrap_rdata", got_d[k], 0);
    end
    do_read(BASE, 12, 3, 2, 1, -1, 0, 2);
    do_read(BASE, 13, 3, 2, 1, -1, 0, -1);
    for (int k = 0; k < 4; k++) chk("after_rst_rdata", got_d[k], 32'(k + 1));
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a = BASE - 32'd64 + 32'($urandom_range(0, 4096 + 128));
      int len = $urandom_range(0, 15);
      logic [2:0] s = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 3)) : 3'd2;
      logic [1:0] b = 2'($urandom_range(0, 5) == 0 ? $urandom_range(0, 2) : 1);
      if ($urandom_range(1)) begin
        for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
        do_write(a, 4'($urandom), len, s, b, $urandom_range(0, 3) == 0 ? $urandom_range(0, len) : len);
      end else
        do_read(a, 4'($urandom), len, s, b, $urandom_range(0, len), $urandom_range(0, 4), -1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
